// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select and an automatic scan
// sequencer that dwells DWELL cycles on each channel before advancing.
module mux_scan_n #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 1,
  parameter  int DWELL    = 1,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           cur_sel,
  output logic                      out_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int CNTW = $clog2(DWELL + 1);

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(CHANNELS - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SELW-1:0]  cur_sel_q, cur_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;
  logic [CNTW-1:0]  dwell_q, dwell_d;

  logic [WIDTH-1:0] chan [CHANNELS];
  logic             sel_in_range;

  // Split the flat input bus into one word per channel
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan[k] = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Only non-power-of-two channel counts can see an out-of-range select
  always_comb begin
    sel_in_range = (int'(sel) < CHANNELS);
  end

  // Next-state logic: mode picks the state every cycle; scan restarts at channel 0
  always_comb begin
    state_d     = mode ? ST_SCAN : ST_MANUAL;
    out_d       = out_q;
    cur_sel_d   = cur_sel_q;
    out_valid_d = 1'b1;
    wrap_d      = 1'b0;
    sel_err_d   = 1'b0;
    dwell_d     = dwell_q;

    if (!mode) begin
      cur_sel_d = sel;
      dwell_d   = '0;
      sel_err_d = !sel_in_range;
      out_d     = sel_in_range ? chan[sel] : '0;
    end else begin
      if (state_q == ST_MANUAL) begin
        cur_sel_d = '0;
        dwell_d   = '0;
      end else if (!hold) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (cur_sel_q == LAST_CH) begin
            cur_sel_d = '0;
            wrap_d    = 1'b1;
          end else begin
            cur_sel_d = cur_sel_q + SELW'(1);
          end
        end else begin
          dwell_d = dwell_q + CNTW'(1);
        end
      end
      out_d = chan[cur_sel_d];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_MANUAL;
      out_q       <= '0;
      cur_sel_q   <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      sel_err_q   <= sel_err_d;
      dwell_q     <= dwell_d;
    end
  end

  assign out       = out_q;
  assign cur_sel   = cur_sel_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign sel_err   = sel_err_q;

endmodule
